// File: rtl/hex_display_pkg.sv
// Shared constants and FSM state type for the hex display arbiter slice.
package hex_display_pkg;

    localparam int unsigned HEX_DIGITS    = 8;
    localparam int unsigned HEX_BUS_W     = 32;
    localparam logic [7:0]  HEX_BLANK_ALL = 8'hFF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_DWELL = 1'b1
    } state_t;

endpackage

// File: rtl/hex_display_arbiter_if.sv
// Requester-side bus: per-requester valid, 32-bit nibble value and digit-blank mask, one-hot ready.
interface hex_display_arbiter_if
    import hex_display_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);

    logic [NUM_REQ-1:0]            req_valid;
    logic [HEX_BUS_W*NUM_REQ-1:0]  req_data;
    logic [HEX_DIGITS*NUM_REQ-1:0] req_blank;
    logic [NUM_REQ-1:0]            req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_blank,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_blank,
        output req_ready
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first asserted request starting at ptr, wrapping modulo N.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] gnt_idx,
    output logic          any
);

    int unsigned idx;

    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + k) % N;
            // Match by equality so every select uses a constant loop index.
            for (int unsigned j = 0; j < N; j++) begin
                if (j == idx && !any && req[j]) begin
                    grant[j] = 1'b1;
                    gnt_idx  = PW'(j);
                    any      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// Shares the 8-digit hex display among NUM_REQ requesters with round-robin grants
// and a minimum dwell time per winner.
module hex_display_arbiter
    import hex_display_pkg::*;
#(
    parameter  int unsigned NUM_REQ      = 4,
    parameter  int unsigned DWELL_CYCLES = 50_000_000,
    localparam int unsigned CNT_W        = $clog2(DWELL_CYCLES + 1),
    localparam int unsigned PW           = $clog2(NUM_REQ)
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    hex_display_arbiter_if.slave  bus,
    input  logic                  freeze,
    output logic [HEX_BUS_W-1:0]  hex_display_32,
    output logic [HEX_DIGITS-1:0] hex_blank,
    output logic [2:0]            owner_id,
    output logic                  owner_valid,
    output logic                  busy
);

    state_t                 state;
    logic [PW-1:0]          rr_ptr;
    logic [PW-1:0]          gnt_idx;
    logic [NUM_REQ-1:0]     grant;
    logic                   any;
    logic                   fire;
    logic [CNT_W-1:0]       cnt;
    logic [HEX_BUS_W-1:0]   sel_data;
    logic [HEX_DIGITS-1:0]  sel_blank;

    rr_arbiter #(.N(NUM_REQ)) u_rr_arbiter (
        .req     (bus.req_valid),
        .ptr     (rr_ptr),
        .grant   (grant),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // Ready is offered only in IDLE; the reset term keeps it low during a reset cycle.
    assign fire          = (state == ST_IDLE) && !freeze && !reset && any;
    assign bus.req_ready = fire ? grant : '0;

    always_comb begin
        sel_data  = '0;
        sel_blank = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_data  = bus.req_data[i*HEX_BUS_W +: HEX_BUS_W];
                sel_blank = bus.req_blank[i*HEX_DIGITS +: HEX_DIGITS];
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            cnt            <= '0;
            hex_display_32 <= '0;
            hex_blank      <= HEX_BLANK_ALL;
            owner_id       <= '0;
            owner_valid    <= 1'b0;
            busy           <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fire) begin
                        hex_display_32 <= sel_data;
                        hex_blank      <= sel_blank;
                        owner_id       <= 3'(gnt_idx);
                        owner_valid    <= 1'b1;
                        rr_ptr         <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                        cnt            <= CNT_W'(DWELL_CYCLES - 1);
                        busy           <= 1'b1;
                        state          <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (cnt == '0) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Directed bench for hex_display_arbiter with NUM_REQ=4, DWELL_CYCLES=4.
module tb_hex_display_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        freeze;
    logic [31:0] disp;
    logic [7:0]  blank;
    logic [2:0]  owner_id;
    logic        owner_valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] dat [4];
    logic [7:0]  blk [4];

    always #5 clk = ~clk;

    hex_display_arbiter_if #(.NUM_REQ(4)) bus ();

    hex_display_arbiter #(
        .NUM_REQ      (4),
        .DWELL_CYCLES (4)
    ) dut (
        .CLOCK_50       (clk),
        .reset          (reset),
        .bus            (bus),
        .freeze         (freeze),
        .hex_display_32 (disp),
        .hex_blank      (blank),
        .owner_id       (owner_id),
        .owner_valid    (owner_valid),
        .busy           (busy)
    );

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        freeze = 1'b0;
        bus.req_valid = '0;
        next_cyc(); next_cyc(); #1;
        total++; if (disp !== 32'h0) begin bad++; $display("FAIL reset_disp: got %h want %h", disp, 32'h0); end
        total++; if (blank !== 8'hFF) begin bad++; $display("FAIL reset_blank: got %h want %h", blank, 8'hFF); end
        total++; if (owner_id !== 3'd0) begin bad++; $display("FAIL reset_owner: got %0d want 0", owner_id); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            next_cyc(); #1;
            total++; if (blank !== 8'hFF) begin bad++; $display("FAIL idle_blank[%0d]: got %h want ff", i, blank); end
            total++; if (owner_valid !== 1'b0) begin bad++; $display("FAIL idle_owner_valid[%0d]: got %b want 0", i, owner_valid); end
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL idle_ready[%0d]: got %b want 0000", i, bus.req_ready); end
        end
    endtask

    task automatic test_single;
        bus.req_valid = 4'b0100; #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
        next_cyc(); bus.req_valid = '0; #1;
        total++; if (disp !== 32'h1234_5678) begin bad++; $display("FAIL single_disp: got %h want 12345678", disp); end
        total++; if (owner_id !== 3'd2) begin bad++; $display("FAIL single_owner: got %0d want 2", owner_id); end
        total++; if (owner_valid !== 1'b1) begin bad++; $display("FAIL single_owner_valid: got %b want 1", owner_valid); end
        total++; if (blank !== 8'h00) begin bad++; $display("FAIL single_blank: got %h want 00", blank); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy0: got %b want 1", busy); end
        for (int i = 1; i < 4; i++) begin
            next_cyc(); #1;
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy%0d: got %b want 1", i, busy); end
            total++; if (disp !== 32'h1234_5678) begin bad++; $display("FAIL single_hold%0d: got %h want 12345678", i, disp); end
        end
        next_cyc(); #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy_end: got %b want 0", busy); end
    endtask

    task automatic test_round_robin;
        int order [5];
        int cc;
        int last;
        int k;
        order = '{0, 1, 2, 3, 0};
        cc = 0;
        last = 0;
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        bus.req_valid = 4'hF; #1;
        for (int n = 0; n < 5; n++) begin
            k = 0;
            while (bus.req_ready === 4'b0000 && k < 20) begin
                next_cyc(); #1; cc++; k++;
            end
            total++; if (k >= 20) begin bad++; $display("FAIL rr_timeout[%0d]: got no grant within 20 cycles want grant", n); end
            total++; if (bus.req_ready !== (4'b0001 << order[n])) begin bad++; $display("FAIL rr_ready[%0d]: got %b want req %0d", n, bus.req_ready, order[n]); end
            if (n > 0) begin
                total++; if (cc - last != 5) begin bad++; $display("FAIL rr_gap[%0d]: got %0d want 5", n, cc - last); end
            end
            last = cc;
            next_cyc(); #1; cc++;
            total++; if (owner_id !== 3'(order[n])) begin bad++; $display("FAIL rr_owner[%0d]: got %0d want %0d", n, owner_id, order[n]); end
            total++; if (disp !== dat[order[n]]) begin bad++; $display("FAIL rr_disp[%0d]: got %h want %h", n, disp, dat[order[n]]); end
            total++; if (blank !== blk[order[n]]) begin bad++; $display("FAIL rr_blank[%0d]: got %h want %h", n, blank, blk[order[n]]); end
        end
        bus.req_valid = '0;
        for (int i = 0; i < 4; i++) next_cyc();
    endtask

    task automatic test_freeze;
        freeze = 1'b1;
        bus.req_valid = 4'b0010; #1;
        for (int i = 0; i < 6; i++) begin
            total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL frz_ready[%0d]: got %b want 0000", i, bus.req_ready); end
            total++; if (disp !== dat[0]) begin bad++; $display("FAIL frz_disp[%0d]: got %h want %h", i, disp, dat[0]); end
            next_cyc(); #1;
        end
        freeze = 1'b0; #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL frz_release_ready: got %b want 0010", bus.req_ready); end
        next_cyc(); bus.req_valid = '0; #1;
        total++; if (owner_id !== 3'd1) begin bad++; $display("FAIL frz_owner: got %0d want 1", owner_id); end
        total++; if (disp !== dat[1]) begin bad++; $display("FAIL frz_disp_after: got %h want %h", disp, dat[1]); end
    endtask

    task automatic test_reset_mid_dwell;
        next_cyc();
        reset = 1'b1;
        bus.req_valid = 4'hF; #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready_dwell: got %b want 0000", bus.req_ready); end
        next_cyc(); #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL mid_ready_in_reset: got %b want 0000", bus.req_ready); end
        total++; if (disp !== 32'h0) begin bad++; $display("FAIL mid_disp: got %h want 00000000", disp); end
        total++; if (blank !== 8'hFF) begin bad++; $display("FAIL mid_blank: got %h want ff", blank); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", busy); end
        total++; if (owner_valid !== 1'b0) begin bad++; $display("FAIL mid_owner_valid: got %b want 0", owner_valid); end
        reset = 1'b0; #1;
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL mid_ptr_ready: got %b want 0001", bus.req_ready); end
        next_cyc(); bus.req_valid = '0; #1;
        total++; if (owner_id !== 3'd0) begin bad++; $display("FAIL mid_owner: got %0d want 0", owner_id); end
        for (int i = 0; i < 4; i++) next_cyc();
    endtask

    task automatic test_valid_drop;
        bus.req_valid = 4'b0100; #1;
        total++; if (bus.req_ready !== 4'b0100) begin bad++; $display("FAIL drop_pre_ready: got %b want 0100", bus.req_ready); end
        next_cyc(); bus.req_valid = 4'b1010; #1;
        total++; if (owner_id !== 3'd2) begin bad++; $display("FAIL drop_pre_owner: got %0d want 2", owner_id); end
        next_cyc(); next_cyc(); next_cyc();
        bus.req_valid = 4'b0010; #1;
        total++; if (bus.req_ready !== 4'b0000) begin bad++; $display("FAIL drop_dwell_ready: got %b want 0000", bus.req_ready); end
        next_cyc(); #1;
        total++; if (bus.req_ready !== 4'b0010) begin bad++; $display("FAIL drop_ready: got %b want 0010", bus.req_ready); end
        next_cyc(); bus.req_valid = '0; #1;
        total++; if (owner_id !== 3'd1) begin bad++; $display("FAIL drop_owner: got %0d want 1", owner_id); end
        total++; if (disp !== dat[1]) begin bad++; $display("FAIL drop_disp: got %h want %h", disp, dat[1]); end
        for (int i = 0; i < 6; i++) next_cyc();
        #1;
        total++; if (owner_id !== 3'd1) begin bad++; $display("FAIL drop_owner_hold: got %0d want 1", owner_id); end
        total++; if (disp !== dat[1]) begin bad++; $display("FAIL drop_disp_hold: got %h want %h", disp, dat[1]); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        dat[0] = 32'hDEAD_0000; blk[0] = 8'h80;
        dat[1] = 32'h0000_BEEF; blk[1] = 8'h0F;
        dat[2] = 32'h1234_5678; blk[2] = 8'h00;
        dat[3] = 32'hFFFF_0003; blk[3] = 8'hF0;
        for (int i = 0; i < 4; i++) begin
            bus.req_data[i*32 +: 32] = dat[i];
            bus.req_blank[i*8 +: 8]  = blk[i];
        end
        bus.req_valid = '0;
        reset = 1'b1;
        freeze = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_freeze();
        test_reset_mid_dwell();
        test_valid_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
